regfile_weight_loader: RTL and testbench

Write-port sequencer and arbiter for the 32×32 register file. It shares the single register-file write port between CPU writeback and a streaming weight loader. On command, the loader fills WEIGHT_SIZE consecutive weight-row registers from a valid/ready stream, then pulses done so the FC/Conv datapath can consume the weight matrix. It sits between the pipeline writeback stage and the register file's RDaddr_i/RDdata_i/RegWrite_i/is_pos_i inputs.

---
 rtl/regfile_weight_loader_if.sv | 26 ++
 rtl/regfile_weight_loader.sv | 113 +++++++++++
 tb/tb_regfile_weight_loader.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_weight_loader_if.sv
// Write-port bus for the weight loader: CPU writeback request, weight stream, and register-file write port.
// The slave modport is the loader's view; the master modport drives it from the other side.
interface regfile_weight_loader_if;
    logic        cpu_we_i;
    logic [4:0]  cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic [3:0]  cpu_pos_i;
    logic        stall_o;
    logic        ld_valid_i;
    logic [31:0] ld_data_i;
    logic        ld_ready_o;
    logic [4:0]  RDaddr_o;
    logic [31:0] RDdata_o;
    logic        RegWrite_o;
    logic [3:0]  is_pos_o;

    modport slave (
        input  cpu_we_i, cpu_addr_i, cpu_data_i, cpu_pos_i, ld_valid_i, ld_data_i,
        output stall_o, ld_ready_o, RDaddr_o, RDdata_o, RegWrite_o, is_pos_o
    );

    modport master (
        output cpu_we_i, cpu_addr_i, cpu_data_i, cpu_pos_i, ld_valid_i, ld_data_i,
        input  stall_o, ld_ready_o, RDaddr_o, RDdata_o, RegWrite_o, is_pos_o
    );
endinterface

// File: rtl/regfile_weight_loader.sv
// Shares the register-file write port between CPU writeback (priority) and a streaming weight-row loader.
// Optional REGFILE_LOADER_ABORT_EN adds abort_i to cancel a load in progress.
module regfile_weight_loader #(
    parameter int WEIGHT_SIZE = 4,
    parameter int BASE_ADDR   = 12
) (
    input  logic                               clk_i,
    input  logic                               reset,
    input  logic                               start_i,
`ifdef REGFILE_LOADER_ABORT_EN
    input  logic                               abort_i,
`endif
    regfile_weight_loader_if.slave             bus,
    output logic                               busy_o,
    output logic                               done_o,
    output logic [$clog2(WEIGHT_SIZE+1)-1:0]   row_cnt_o
);
    localparam int             CW     = $clog2(WEIGHT_SIZE + 1);
    localparam logic [5:0]     WIN_LO = 6'(BASE_ADDR);
    localparam logic [5:0]     WIN_HI = 6'(BASE_ADDR + WEIGHT_SIZE);
    localparam logic [CW-1:0]  LAST   = CW'(WEIGHT_SIZE - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] row_cnt_q, row_cnt_d;
    logic          we_q, we_d;
    logic [4:0]    addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [3:0]    pos_q, pos_d;

    logic in_win, stall, cpu_fwd, abort_act, ld_ready, beat;

    assign in_win = ({1'b0, bus.cpu_addr_i} >= WIN_LO) && ({1'b0, bus.cpu_addr_i} < WIN_HI);
    assign stall  = bus.cpu_we_i && (state_q != IDLE) && in_win;
    assign cpu_fwd = bus.cpu_we_i && !stall;

`ifdef REGFILE_LOADER_ABORT_EN
    assign abort_act = (state_q == LOAD) && abort_i;
`else
    assign abort_act = 1'b0;
`endif

    // Only a forwarded CPU write takes the port; a stalled in-window write must not
    // block the loader, otherwise the stall could never clear.
    assign ld_ready = (state_q == LOAD) && !cpu_fwd && !abort_act;
    assign beat     = bus.ld_valid_i && ld_ready;

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        pos_d     = pos_q;

        unique case (state_q)
            IDLE: if (start_i) begin
                state_d   = LOAD;
                row_cnt_d = '0;
            end
            LOAD: if (abort_act) begin
                state_d   = IDLE;
                row_cnt_d = '0;
            end else if (beat) begin
                row_cnt_d = row_cnt_q + CW'(1);
                if (row_cnt_q == LAST) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (cpu_fwd) begin
            we_d   = 1'b1;
            addr_d = bus.cpu_addr_i;
            data_d = bus.cpu_data_i;
            pos_d  = bus.cpu_pos_i;
        end else if (beat) begin
            we_d   = 1'b1;
            addr_d = 5'(BASE_ADDR) + 5'(row_cnt_q);
            data_d = bus.ld_data_i;
            pos_d  = 4'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            row_cnt_q <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            pos_q     <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            pos_q     <= pos_d;
        end
    end

    assign bus.stall_o    = stall;
    assign bus.ld_ready_o = ld_ready;
    assign bus.RegWrite_o = we_q;
    assign bus.RDaddr_o   = addr_q;
    assign bus.RDdata_o   = data_q;
    assign bus.is_pos_o   = pos_q;
    assign busy_o         = (state_q != IDLE);
    assign done_o         = (state_q == DONE);
    assign row_cnt_o      = row_cnt_q;
endmodule

// File: tb/tb_regfile_weight_loader.sv
// Scoreboard bench for regfile_weight_loader: directed scenarios plus randomized traffic against a cycle-level model.
module tb_regfile_weight_loader;
    localparam int WS = 4;
    localparam int BA = 12;

    logic       clk_i = 1'b0;
    logic       reset;
    logic       start_i;
`ifdef REGFILE_LOADER_ABORT_EN
    logic       abort_i;
`endif
    logic       busy_o, done_o;
    logic [2:0] row_cnt_o;

    regfile_weight_loader_if bus();

    regfile_weight_loader #(.WEIGHT_SIZE(WS), .BASE_ADDR(BA)) dut (
        .clk_i     (clk_i),
        .reset     (reset),
        .start_i   (start_i),
`ifdef REGFILE_LOADER_ABORT_EN
        .abort_i   (abort_i),
`endif
        .bus       (bus),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .row_cnt_o (row_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic [3:0]  p;
    } wr_t;

    wr_t exp_q[$];
    int  done_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;

    // Reference model: what the loader is doing, in plain terms
    bit  m_load, m_done;
    int  m_rows;
    bit  last_stall;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus: drive at negedge, check combinational outputs, then predict the edge.
    task automatic step(input bit st, input bit we, input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] p, input bit v, input logic [31:0] ld, input bit ab);
        bit win, stall_e, fwd, ab_e, rdy_e;
        @(negedge clk_i);
        start_i        = st;
        bus.cpu_we_i   = we;
        bus.cpu_addr_i = a;
        bus.cpu_data_i = d;
        bus.cpu_pos_i  = p;
        bus.ld_valid_i = v;
        bus.ld_data_i  = ld;
`ifdef REGFILE_LOADER_ABORT_EN
        abort_i = ab;
        ab_e    = ab && m_load;
`else
        ab_e    = 1'b0 & ab;
`endif
        #1;
        win     = (int'(a) >= BA) && (int'(a) < BA + WS);
        stall_e = we && (m_load || m_done) && win;
        fwd     = we && !stall_e;
        rdy_e   = m_load && !fwd && !ab_e;
        chk("stall_o", 32'(bus.stall_o), 32'(stall_e));
        chk("ld_ready_o", 32'(bus.ld_ready_o), 32'(rdy_e));
        chk("busy_o", 32'(busy_o), 32'(m_load || m_done));
        chk("row_cnt_o", 32'(row_cnt_o), 32'(m_rows));
        if (fwd) exp_q.push_back('{a: a, d: d, p: p});
        if (rdy_e && v) exp_q.push_back('{a: 5'(BA + m_rows), d: ld, p: 4'h0});
        last_stall = stall_e;
        if (m_load) begin
            if (ab_e) begin
                m_load = 0;
                m_rows = 0;
            end else if (rdy_e && v) begin
                m_rows++;
                if (m_rows == WS) begin
                    m_load = 0;
                    m_done = 1;
                    done_q.push_back(cyc + 1);
                end
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (st) begin
            m_load = 1;
            m_rows = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 5'd0, 32'h0, 4'h0, 0, 32'h0, 0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_RDaddr"}, 32'(bus.RDaddr_o), 32'h0);
        chk({tag, "_RDdata"}, bus.RDdata_o, 32'h0);
        chk({tag, "_RegWrite"}, 32'(bus.RegWrite_o), 32'h0);
        chk({tag, "_is_pos"}, 32'(bus.is_pos_o), 32'h0);
        chk({tag, "_done"}, 32'(done_o), 32'h0);
        chk({tag, "_busy"}, 32'(busy_o), 32'h0);
        chk({tag, "_row_cnt"}, 32'(row_cnt_o), 32'h0);
        chk({tag, "_ld_ready"}, 32'(bus.ld_ready_o), 32'h0);
        chk({tag, "_stall"}, 32'(bus.stall_o), 32'h0);
    endtask

    // Asynchronous reset pulse entirely between clock edges
    task automatic mid_reset();
        @(negedge clk_i);
        start_i        = 0;
        bus.cpu_we_i   = 0;
        bus.ld_valid_i = 0;
`ifdef REGFILE_LOADER_ABORT_EN
        abort_i = 0;
`endif
        #2 reset = 1;
        #1 check_reset_values("midrst");
        #1 reset = 0;
        m_load = 0; m_done = 0; m_rows = 0; last_stall = 0;
    endtask

    // Monitor: pops expected writes/done pulses whenever the DUT presents them
    initial begin
        wr_t e;
        int  dc;
        forever begin
            @(posedge clk_i);
            #1;
            if (bus.RegWrite_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write: got addr %0d data %h, expected none", bus.RDaddr_o, bus.RDdata_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(bus.RDaddr_o), 32'(e.a));
                    chk("wr_data", bus.RDdata_o, e.d);
                    chk("wr_pos", 32'(bus.is_pos_o), 32'(e.p));
                end
            end
            if (done_o === 1'b1) begin
                chk("done_with_last_row", {26'h0, bus.RegWrite_o, bus.RDaddr_o}, {26'h0, 1'b1, 5'(BA + WS - 1)});
                if (done_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done: got pulse at cycle %0d, expected none", cyc);
                end else begin
                    dc = done_q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(dc));
                end
            end
        end
    end

    initial begin
        logic [31:0] vals [4];
        bit          hw;
        logic [4:0]  ha;
        logic [31:0] hd;
        logic [3:0]  hp;
        vals[0] = 32'h1743030f; vals[1] = 32'h08785b1f; vals[2] = 32'h01010101; vals[3] = 32'h02020202;
        m_load = 0; m_done = 0; m_rows = 0; last_stall = 0;

        reset = 1; start_i = 0;
        bus.cpu_we_i = 0; bus.cpu_addr_i = 0; bus.cpu_data_i = 0; bus.cpu_pos_i = 0;
        bus.ld_valid_i = 0; bus.ld_data_i = 0;
`ifdef REGFILE_LOADER_ABORT_EN
        abort_i = 0;
`endif
        #1 check_reset_values("rst");
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) reset = 0;

        // Basic load with back-to-back beats
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < WS; i++) step(0, 0, 0, 0, 0, 1, vals[i], 0);
        idle(2);

        // Out-of-window CPU write mid-stream steals one cycle
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'haaaa0000, 0);
        step(0, 1, 5'd5, 32'hdeadbeef, 4'h3, 1, 32'haaaa0001, 0);
        for (int i = 1; i < WS; i++) step(0, 0, 0, 0, 0, 1, 32'haaaa0000 + 32'(i), 0);
        idle(2);

        // In-window CPU write stalls through DONE, then lands in IDLE
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < WS + 1; i++) step(0, 1, 5'd13, 32'hc0de0013, 4'h7, 1, 32'hbbbb0000 + 32'(i), 0);
        step(0, 1, 5'd13, 32'hc0de0013, 4'h7, 0, 0, 0);
        idle(2);

        // start_i held through LOAD and DONE is ignored
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < WS + 1; i++) step(1, 0, 0, 0, 0, 1, 32'hcccc0000 + 32'(i), 0);
        idle(2);

        // Reset after two rows
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'hdddd0000, 0);
        step(0, 0, 0, 0, 0, 1, 32'hdddd0001, 0);
        mid_reset();
        idle(3);

`ifdef REGFILE_LOADER_ABORT_EN
        // Abort after two rows, then a fresh load restarts at row 0
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'heeee0000, 0);
        step(0, 0, 0, 0, 0, 1, 32'heeee0001, 0);
        step(0, 0, 0, 0, 0, 1, 32'heeee0002, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < WS; i++) step(0, 0, 0, 0, 0, 1, 32'hffff0000 + 32'(i), 0);
        idle(2);
`endif

        // Randomized traffic; a stalled CPU write is held until it goes through
        hw = 0; ha = 0; hd = 0; hp = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!last_stall) begin
                hw = ($urandom_range(0, 3) == 0);
                ha = ($urandom_range(0, 1) == 0) ? 5'(BA + $urandom_range(0, WS - 1)) : 5'($urandom_range(0, 31));
                hd = $urandom;
                hp = 4'($urandom);
            end
            step($urandom_range(0, 7) == 0, hw, ha, hd, hp, $urandom_range(0, 3) != 0, $urandom,
                 $urandom_range(0, 31) == 0);
            if (i == 1000) mid_reset();
        end
        idle(4);

        chk("pending_writes", 32'(exp_q.size()), 32'h0);
        chk("pending_done", 32'(done_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
